soc_timer_axil_driver: RTL



---
 rtl/soc_timer_reg_pkg.sv | 36 +++
 rtl/soc_timer_axil_xact.sv | 138 +++++++++++++
 rtl/soc_timer_axil_driver.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/soc_timer_reg_pkg.sv
// Register map of the SoC timer slave, AXI response codes, and the state
// encodings shared by the AXI4-Lite driver and its transaction engine.
package soc_timer_reg_pkg;

    localparam logic [31:0] LOAD_OFFSET       = 32'h0000_0000;
    localparam logic [31:0] CONTROL_OFFSET    = 32'h0000_0004;
    localparam logic [31:0] VALUE_OFFSET      = 32'h0000_0008;
    localparam logic [31:0] INT_STATUS_OFFSET = 32'h0000_000C;
    localparam logic [31:0] INT_CLEAR_OFFSET  = 32'h0000_0010;

    localparam int CTRL_ENABLE_BIT      = 0;
    localparam int CTRL_AUTO_RELOAD_BIT = 1;
    localparam int CTRL_IRQ_MASK_BIT    = 2;
    localparam int IRQ_FLAG_BIT         = 0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        DRV_IDLE,
        DRV_WR_LOAD,
        DRV_WR_CTRL,
        DRV_RD_STAT,
        DRV_WR_CLR
    } drv_state_t;

    typedef enum logic [2:0] {
        XACT_IDLE,
        XACT_WR_ADDR,
        XACT_WR_RESP,
        XACT_RD_ADDR,
        XACT_RD_DATA
    } xact_state_t;

endpackage

// File: rtl/soc_timer_axil_xact.sv
// Single-beat AXI4-Lite read or write engine; one transaction at a time.
// done/rdata/resp_err are combinational on the final handshake so the caller can chain with no idle gap.
module soc_timer_axil_xact
    import soc_timer_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        resp_err,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    xact_state_t xs_q, xs_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic b_done;
    logic r_done;

    assign b_done   = (xs_q == XACT_WR_RESP) && m_bvalid;
    assign r_done   = (xs_q == XACT_RD_DATA) && m_rvalid;
    assign done     = b_done || r_done;
    assign rdata    = m_rdata;
    assign resp_err = (b_done && (m_bresp != RESP_OKAY)) || (r_done && (m_rresp != RESP_OKAY));

    always_comb begin
        xs_d      = xs_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        unique case (xs_q)
            XACT_WR_ADDR: begin
                // AW and W retire independently; B is only accepted once both have gone
                awvalid_d = awvalid_q && !m_awready;
                wvalid_d  = wvalid_q && !m_wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    xs_d     = XACT_WR_RESP;
                end
            end
            XACT_WR_RESP: begin
                if (m_bvalid) begin
                    bready_d = 1'b0;
                    xs_d     = XACT_IDLE;
                end
            end
            XACT_RD_ADDR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    xs_d      = XACT_RD_DATA;
                end
            end
            XACT_RD_DATA: begin
                if (m_rvalid) begin
                    rready_d = 1'b0;
                    xs_d     = XACT_IDLE;
                end
            end
            default: ;
        endcase
        if (start) begin
            addr_d  = addr;
            wdata_d = wdata;
            if (is_write) begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                xs_d      = XACT_WR_ADDR;
            end else begin
                arvalid_d = 1'b1;
                xs_d      = XACT_RD_ADDR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs_q      <= XACT_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            xs_q      <= xs_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = 4'hF;
    assign m_awvalid = awvalid_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

endmodule

// File: rtl/soc_timer_axil_driver.sv
// Programs the SoC timer (LOAD then CONTROL) on command and services its
// interrupt (read INT_STATUS, write INT_CLEAR) over AXI4-Lite.
module soc_timer_axil_driver
    import soc_timer_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_load,
    input  logic [2:0]        cmd_ctrl,
    input  logic              irq_in,
    output logic              irq_evt,
    output logic              busy,
    output logic              err,
    output logic [31:0]       m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [31:0]       m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    drv_state_t  state_q, state_d;
    logic [31:0] load_q, load_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        err_q, err_d;
    logic        evt_q, evt_d;

    logic        x_start;
    logic        x_is_write;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic        x_done;
    logic [31:0] x_rdata;
    logic        x_resp_err;
    logic        unused_rdata;

    assign cmd_ready    = rst_n && (state_q == DRV_IDLE) && !irq_in;
    assign unused_rdata = ^x_rdata;

    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        ctrl_d  = ctrl_q;
        err_d   = err_q;
        evt_d   = 1'b0;
        unique case (state_q)
            DRV_IDLE: begin
                if (irq_in) begin
                    state_d = DRV_RD_STAT;
                end else if (cmd_valid) begin
                    load_d  = cmd_load;
                    ctrl_d  = cmd_ctrl;
                    err_d   = 1'b0;
                    state_d = DRV_WR_LOAD;
                end
            end
            DRV_WR_LOAD: begin
                if (x_done) begin
                    err_d   = err_q | x_resp_err;
                    state_d = x_resp_err ? DRV_IDLE : DRV_WR_CTRL;
                end
            end
            DRV_WR_CTRL: begin
                if (x_done) begin
                    err_d   = err_q | x_resp_err;
                    state_d = DRV_IDLE;
                end
            end
            DRV_RD_STAT: begin
                if (x_done) begin
                    err_d = err_q | x_resp_err;
                    if (!x_resp_err && x_rdata[IRQ_FLAG_BIT]) state_d = DRV_WR_CLR;
                    else                                      state_d = DRV_IDLE;
                end
            end
            DRV_WR_CLR: begin
                if (x_done) begin
                    err_d   = err_q | x_resp_err;
                    evt_d   = !x_resp_err;
                    state_d = DRV_IDLE;
                end
            end
            default: state_d = DRV_IDLE;
        endcase
    end

    // Launch the next transaction on the same edge the state is entered, so
    // consecutive transfers leave no dead cycle between them.
    always_comb begin
        x_start    = (state_d != state_q) && (state_d != DRV_IDLE);
        x_is_write = (state_d != DRV_RD_STAT);
        x_addr     = BASE_ADDR + LOAD_OFFSET;
        x_wdata    = load_d;
        unique case (state_d)
            DRV_WR_CTRL: begin
                x_addr  = BASE_ADDR + CONTROL_OFFSET;
                x_wdata = {29'b0, ctrl_q};
            end
            DRV_RD_STAT: begin
                x_addr  = BASE_ADDR + INT_STATUS_OFFSET;
                x_wdata = 32'h0;
            end
            DRV_WR_CLR: begin
                x_addr  = BASE_ADDR + INT_CLEAR_OFFSET;
                x_wdata = 32'h1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DRV_IDLE;
            load_q  <= '0;
            ctrl_q  <= '0;
            err_q   <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            ctrl_q  <= ctrl_d;
            err_q   <= err_d;
            evt_q   <= evt_d;
        end
    end

    assign irq_evt = evt_q;
    assign busy    = (state_q != DRV_IDLE);
    assign err     = err_q;

    soc_timer_axil_xact u_xact (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (x_start),
        .is_write  (x_is_write),
        .addr      (x_addr),
        .wdata     (x_wdata),
        .done      (x_done),
        .rdata     (x_rdata),
        .resp_err  (x_resp_err),
        .m_awaddr  (m_awaddr),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready)
    );

endmodule
